// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC serial transmitter.
//   state_t      : transmitter FSM states (IDLE, SHIFT, GAP)
//   FRAME_BITS   : bits per serial frame (control nibble + sample)
//   SAMPLE_BITS  : width of one DAC sample
//   CFG_BITS     : width of the control prefix
//   build_frame  : assembles the on-wire frame word, MSB transmitted first
package dac_spi_pkg;

   localparam int FRAME_BITS  = 16;
   localparam int SAMPLE_BITS = 12;
   localparam int CFG_BITS    = FRAME_BITS - SAMPLE_BITS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic [CFG_BITS-1:0]    cfg,
      input logic [SAMPLE_BITS-1:0] sample
   );
      return {cfg, sample};
   endfunction

endpackage

// File: rtl/dac_spi_tx_clkgen.sv
// spi_clkgen: serial clock generator for dac_spi_tx.
// While en is high, sclk spends CLK_DIV clk cycles low then CLK_DIV cycles
// high, starting low. While en is low the divider is held cleared and sclk
// is forced low, so every enable starts with a full low phase.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   en    in  run the divider (transmitter is shifting)
//   sclk  out registered serial clock level
//   rise  out strobe: sclk goes high on the coming clk edge
//   fall  out strobe: sclk goes low on the coming clk edge
module spi_clkgen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] div_cnt_reg, div_cnt_next;
   logic       sclk_reg, sclk_next;
   logic       phase_end;

   // The strobes are combinational so the transmitter can act on the same
   // edge where sclk changes level.
   always_comb begin
      phase_end    = en && (div_cnt_reg == DIV_LAST);
      rise         = phase_end && !sclk_reg;
      fall         = phase_end && sclk_reg;
      div_cnt_next = div_cnt_reg;
      sclk_next    = sclk_reg;
      if (!en) begin
         div_cnt_next = '0;
         sclk_next    = 1'b0;
      end else if (phase_end) begin
         div_cnt_next = '0;
         sclk_next    = !sclk_reg;
      end else begin
         div_cnt_next = div_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_reg <= '0;
         sclk_reg    <= 1'b0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         sclk_reg    <= sclk_next;
      end
   end

   assign sclk = sclk_reg;

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: streams 12-bit samples to a serial DAC as 16-bit frames
// {CFG, sample}, MSB first. A one-entry holding buffer decouples the sample
// handshake from the frame in flight, so frames run back to back when the
// source keeps the buffer filled.
// Ports:
//   clk           in  system clock
//   rst           in  synchronous active-high reset (aborts any frame)
//   sample_data   in  sample to transmit
//   sample_valid  in  sample_data valid this cycle
//   sample_ready  out holding buffer empty (registered)
//   sclk          out serial clock, idles low
//   cs_n          out frame select, active low, idles high
//   sdo           out serial data, changes on sclk falling edges
//   busy          out high in SHIFT or GAP
//   frame_done    out one-cycle pulse when cs_n returns high
module dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int                  CLK_DIV    = 2,
   parameter int                  GAP_CYCLES = 4,
   parameter logic [CFG_BITS-1:0] CFG        = 4'b0011
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SAMPLE_BITS-1:0] sample_data,
   input  logic                   sample_valid,
   output logic                   sample_ready,
   output logic                   sclk,
   output logic                   cs_n,
   output logic                   sdo,
   output logic                   busy,
   output logic                   frame_done
);

   localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
   localparam logic [4:0] RISE_LAST = 5'(FRAME_BITS);

   state_t                  state_reg, state_next;
   logic [SAMPLE_BITS-1:0]  buf_reg, buf_next;
   logic                    buf_full_reg, buf_full_next;
   logic                    ready_reg, ready_next;
   logic [FRAME_BITS-1:0]   shift_reg, shift_next;
   logic [4:0]              rise_cnt_reg, rise_cnt_next;
   logic [7:0]              gap_cnt_reg, gap_cnt_next;
   logic                    cs_n_reg, cs_n_next;
   logic                    sdo_reg, sdo_next;
   logic                    busy_reg, busy_next;
   logic                    frame_done_reg, frame_done_next;

   logic                    accept;
   logic                    load;
   logic                    sclk_en;
   logic                    sclk_rise;
   logic                    sclk_fall;

   assign sclk_en = (state_reg == ST_SHIFT);

   spi_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk  (clk),
      .rst  (rst),
      .en   (sclk_en),
      .sclk (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_comb begin
      state_next      = state_reg;
      buf_next        = buf_reg;
      buf_full_next   = buf_full_reg;
      shift_next      = shift_reg;
      rise_cnt_next   = rise_cnt_reg;
      gap_cnt_next    = gap_cnt_reg;
      frame_done_next = 1'b0;
      load            = 1'b0;
      accept          = sample_valid && ready_reg;

      case (state_reg)
         ST_IDLE: begin
            if (buf_full_reg) begin
               state_next = ST_SHIFT;
               load       = 1'b1;
            end
         end
         ST_SHIFT: begin
            // Count high phases on the rise; the frame ends on the fall that
            // closes the last high phase, leaving sclk low as cs_n rises.
            if (sclk_rise) begin
               rise_cnt_next = rise_cnt_reg + 5'd1;
            end
            if (sclk_fall) begin
               if (rise_cnt_reg == RISE_LAST) begin
                  state_next      = ST_GAP;
                  gap_cnt_next    = '0;
                  frame_done_next = 1'b1;
               end else begin
                  shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               if (buf_full_reg) begin
                  state_next = ST_SHIFT;
                  load       = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               gap_cnt_next = gap_cnt_reg + 8'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // A load only happens with the buffer full, when ready is low, so it
      // can never coincide with an accept.
      if (load) begin
         shift_next    = build_frame(CFG, buf_reg);
         rise_cnt_next = '0;
         buf_full_next = 1'b0;
      end else if (accept) begin
         buf_next      = sample_data;
         buf_full_next = 1'b1;
      end

      ready_next = !buf_full_next;
      cs_n_next  = (state_next != ST_SHIFT);
      sdo_next   = (state_next == ST_SHIFT) ? shift_next[FRAME_BITS-1] : 1'b0;
      busy_next  = (state_next != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         buf_reg        <= '0;
         buf_full_reg   <= 1'b0;
         ready_reg      <= 1'b1;
         shift_reg      <= '0;
         rise_cnt_reg   <= '0;
         gap_cnt_reg    <= '0;
         cs_n_reg       <= 1'b1;
         sdo_reg        <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         buf_reg        <= buf_next;
         buf_full_reg   <= buf_full_next;
         ready_reg      <= ready_next;
         shift_reg      <= shift_next;
         rise_cnt_reg   <= rise_cnt_next;
         gap_cnt_reg    <= gap_cnt_next;
         cs_n_reg       <= cs_n_next;
         sdo_reg        <= sdo_next;
         busy_reg       <= busy_next;
         frame_done_reg <= frame_done_next;
      end
   end

   assign sample_ready = ready_reg;
   assign cs_n         = cs_n_reg;
   assign sdo          = sdo_reg;
   assign busy         = busy_reg;
   assign frame_done   = frame_done_reg;

endmodule
